write_master: RTL

- Avalon-MM write master: the counterpart of the team's read master.
- User logic pushes words into an internal FIFO; the block posts one word-sized write per FIFO entry to a contiguous or fixed address range set by control_go.
- Sits between a user data producer and the Avalon-MM interconnect.

---
 rtl/write_master_pkg.sv | 15 +
 rtl/write_master_if.sv | 40 ++++
 rtl/write_master_fifo.sv | 53 +++++
 rtl/write_master.sv | 122 ++++++++++++
 4 files changed

// File: rtl/write_master_pkg.sv
// Shared types and helpers for the Avalon-MM write master.
package write_master_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  // Mask that clears the sub-word bits of a byte length (be_width must be a power of 2).
  function automatic logic [63:0] addr_step_mask(input int unsigned be_width);
    return ~(64'(be_width) - 64'd1);
  endfunction

endpackage

// File: rtl/write_master_if.sv
// Avalon-MM write bus between the write master and the interconnect.
// M_AVALON_WRITERESPONSEVALID exists only when WRITE_MASTER_WRITERESPONSE_EN is defined.
interface write_master_if #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int BEW = DW / 8
);
  logic          M_AVALON_WAITREQUEST;
  logic [AW-1:0] M_AVALON_ADDRESS;
  logic          M_AVALON_WRITE;
  logic [DW-1:0] M_AVALON_WRITEDATA;
  logic [BEW-1:0] M_AVALON_BYTEENABLE;
`ifdef WRITE_MASTER_WRITERESPONSE_EN
  logic          M_AVALON_WRITERESPONSEVALID;
`endif

  // Handshake: a beat transfers on a clock edge where WRITE=1 and WAITREQUEST=0;
  // while WAITREQUEST=1 the master holds WRITE, ADDRESS and WRITEDATA unchanged.
  modport master (
    input  M_AVALON_WAITREQUEST,
`ifdef WRITE_MASTER_WRITERESPONSE_EN
    input  M_AVALON_WRITERESPONSEVALID,
`endif
    output M_AVALON_ADDRESS,
    output M_AVALON_WRITE,
    output M_AVALON_WRITEDATA,
    output M_AVALON_BYTEENABLE
  );

  modport slave (
    output M_AVALON_WAITREQUEST,
`ifdef WRITE_MASTER_WRITERESPONSE_EN
    output M_AVALON_WRITERESPONSEVALID,
`endif
    input  M_AVALON_ADDRESS,
    input  M_AVALON_WRITE,
    input  M_AVALON_WRITEDATA,
    input  M_AVALON_BYTEENABLE
  );
endinterface

// File: rtl/write_master_fifo.sv
// Synchronous show-ahead FIFO: rdata is the head word straight from storage.
module write_master_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push_ok, w_pop_ok;

  // A push while full is dropped even if a pop frees a slot at the same edge.
  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign rdata     = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/write_master.sv
// Avalon-MM write master: drains a user FIFO as word writes over a contiguous or fixed range.
// Define WRITE_MASTER_WRITERESPONSE_EN to wait for all write responses before reporting done.
module write_master
  import write_master_pkg::*;
#(
  parameter int AVALON_DATA_WIDTH        = 32,
  parameter int AVALON_ADDRESS_WIDTH     = 32,
  parameter int AVALON_BYTE_ENABLE_WIDTH = AVALON_DATA_WIDTH / 8,
  parameter int FIFO_DEPTH               = 16
) (
  input  logic                                M_AVALON_CLK,
  input  logic                                M_AVALON_RST,
  input  logic                                control_fixed_location,
  input  logic [AVALON_ADDRESS_WIDTH-1:0]     control_write_base,
  input  logic [AVALON_ADDRESS_WIDTH-1:0]     control_write_length,
  input  logic                                control_go,
  output logic                                control_done,
  input  logic                                user_write_buffer,
  input  logic [AVALON_DATA_WIDTH-1:0]        user_buffer_data,
  output logic                                user_buffer_full,
  write_master_if.master                      avm,
  output state_t                              o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]         o_dbg_fifo_count
);
  localparam int AW = AVALON_ADDRESS_WIDTH;
  localparam logic [AW-1:0] STEP     = AW'(AVALON_BYTE_ENABLE_WIDTH);
  localparam logic [AW-1:0] LEN_MASK = AW'(addr_step_mask(AVALON_BYTE_ENABLE_WIDTH));

  state_t                         r_state, w_next_state;
  logic [AW-1:0]                  r_addr, r_len;
  logic                           r_fixed;
  logic [AW-1:0]                  w_len_masked;
  logic                           w_go, w_write, w_accept, w_last;
  logic                           w_fifo_empty, w_fifo_full;
  logic [AVALON_DATA_WIDTH-1:0]   w_fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]    w_fifo_count;

  write_master_fifo #(
    .DW    (AVALON_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AVALON_CLK),
    .rst   (M_AVALON_RST),
    .push  (user_write_buffer),
    .pop   (w_accept),
    .wdata (user_buffer_data),
    .rdata (w_fifo_rdata),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign w_len_masked = control_write_length & LEN_MASK;
  assign w_go         = (r_state == IDLE) && control_go;
  assign w_accept     = w_write && !avm.M_AVALON_WAITREQUEST;
  assign w_last       = w_accept && (r_len == STEP);

`ifdef WRITE_MASTER_WRITERESPONSE_EN
  localparam logic [AW-1:0] ONE = AW'(1);
  logic [AW-1:0] r_outstanding, w_out_next;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !avm.M_AVALON_WRITERESPONSEVALID)      w_out_next = r_outstanding + ONE;
    else if (!w_accept && avm.M_AVALON_WRITERESPONSEVALID) w_out_next = r_outstanding - ONE;
  end

  always_ff @(posedge M_AVALON_CLK) begin
    if (M_AVALON_RST) r_outstanding <= '0;
    else              r_outstanding <= w_out_next;
  end
`endif

  always_ff @(posedge M_AVALON_CLK) begin
    if (M_AVALON_RST) r_state <= IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (control_go && (w_len_masked != '0)) w_next_state = WRITE;
`ifdef WRITE_MASTER_WRITERESPONSE_EN
      WRITE:     if (w_last) w_next_state = WAIT_RESP;
      WAIT_RESP: if (w_out_next == '0) w_next_state = IDLE;
`else
      WRITE:     if (w_last) w_next_state = IDLE;
      WAIT_RESP: w_next_state = IDLE;
`endif
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    control_done = (r_state == IDLE);
    w_write      = (r_state == WRITE) && !w_fifo_empty && (r_len != '0);
  end

  // Base/length/fixed are captured on any go seen in IDLE; a zero masked length never leaves IDLE.
  always_ff @(posedge M_AVALON_CLK) begin
    if (M_AVALON_RST) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_fixed <= 1'b0;
    end else if (w_go) begin
      r_addr  <= control_write_base;
      r_len   <= w_len_masked;
      r_fixed <= control_fixed_location;
    end else if (w_accept) begin
      r_len <= r_len - STEP;
      if (!r_fixed) r_addr <= r_addr + STEP;
    end
  end

  assign avm.M_AVALON_WRITE      = w_write;
  assign avm.M_AVALON_ADDRESS    = r_addr;
  assign avm.M_AVALON_WRITEDATA  = w_fifo_rdata;
  assign avm.M_AVALON_BYTEENABLE = '1;
  assign user_buffer_full        = w_fifo_full;
  assign o_dbg_state             = r_state;
  assign o_dbg_fifo_count        = w_fifo_count;
endmodule
